// File: rtl/weight_pkg.sv
// ============================================================================
// weight_pkg: shared widths and FSM state type for the weight fetch path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package weight_pkg;

    localparam int WGT_ADDR_W = 11;
    localparam int WGT_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wfs_state_e;

endpackage

`default_nettype wire

// File: rtl/weight_skid_fifo.sv
// ============================================================================
// weight_skid_fifo: 2-entry FIFO absorbing the SRAM read latency; head is unregistered.
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_skid_fifo #(
    parameter int WIDTH = 257
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/weight_fetch_streamer.sv
// ============================================================================
// weight_fetch_streamer: streams a run of weight SRAM lines to a valid/ready consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_fetch_streamer
    import weight_pkg::*;
#(
    parameter int ADDR_WIDTH = WGT_ADDR_W,
    parameter int DATA_WIDTH = WGT_DATA_W
) (
    input  logic                  clkb,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_lines,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    output logic                  w_last,
    input  logic                  w_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    wfs_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] deliv_q, deliv_d;
    logic                  inflight_q;

    logic [DATA_WIDTH:0]   w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_count;
    logic                  w_accept;
    logic                  w_push;
    logic [1:0]            w_occ;
    logic                  w_issue;

    assign w_accept = w_valid && w_ready;
    // Credit counts a line leaving this cycle, so back-to-back reads sustain one line per cycle.
    assign w_occ    = w_count + {1'b0, inflight_q} - {1'b0, w_accept};
    assign w_issue  = (state_q == FETCH) && (w_occ < 2'd2);
    assign w_push   = inflight_q && (!w_full || w_accept);

    weight_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clkb),
        .rst_n       (reset_n),
        .push_i      (w_push),
        .push_data_i ({(state_q == DRAIN), doutb}),
        .pop_i       (w_accept),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        num_d    = num_q;
        deliv_d  = deliv_q;
        if (w_issue) begin
            addr_d   = addr_q + ADDR_ONE;
            remain_d = remain_q - ADDR_ONE;
        end
        if (w_accept) begin
            deliv_d = deliv_q + ADDR_ONE;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_lines != '0) begin
                        state_d  = FETCH;
                        addr_d   = base_addr;
                        remain_d = num_lines;
                        num_d    = num_lines;
                        deliv_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (w_issue && (remain_q == ADDR_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && (deliv_q == num_q - ADDR_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            num_q      <= '0;
            deliv_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            num_q      <= num_d;
            deliv_q    <= deliv_d;
            inflight_q <= w_issue;
        end
    end

    assign enb     = w_issue;
    assign addrb   = addr_q;
    assign w_valid = !w_empty;
    assign w_data  = w_head[DATA_WIDTH-1:0];
    // Only the line still in flight once in DRAIN can be the final one, so its tag marks w_last.
    assign w_last  = !w_empty && w_head[DATA_WIDTH];
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

`default_nettype wire
